// File: rtl/branch_cmp_pht_if.sv
// Bundle between the F/D pipeline stages and the branch comparator / PHT.
// The master side is the pipeline; the slave side is branch_cmp_pht.
interface branch_cmp_pht_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic             d_valid;
    logic             d_stall;
    logic [31:0]      d_pc;
    logic [2:0]       d_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             d_pred_taken;
    logic             allow;
    logic             mispredict;

    modport master (
        output f_pc, d_valid, d_stall, d_pc, d_op, src_a, src_b, d_pred_taken,
        input  f_pred_taken, allow, mispredict
    );

    modport slave (
        input  f_pc, d_valid, d_stall, d_pc, d_op, src_a, src_b, d_pred_taken,
        output f_pred_taken, allow, mispredict
    );
endinterface

// File: rtl/branch_cmp_pht.sv
// Decode-stage branch comparator with a 2-bit saturating-counter PHT for F-stage prediction.
// Optional statistics counters are built when BRANCH_CMP_STATS_EN is defined.
module branch_cmp_pht #(
    parameter int         WIDTH       = 32,
    parameter int         PHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    localparam int        IDX_W       = $clog2(PHT_ENTRIES)
) (
    input  logic         clk,
    input  logic         reset,
`ifdef BRANCH_CMP_STATS_EN
    output logic [31:0]  stat_branches,
    output logic [31:0]  stat_misses,
`endif
    branch_cmp_pht_if.slave bus
);

    logic [1:0]       pht_q [PHT_ENTRIES];
    logic [1:0]       pht_d [PHT_ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic             cond_ok;
    logic             cond_true;
    logic             allow;
    logic             update_en;
    logic [1:0]       cnt_d;
    logic             a_neg;
    logic             a_zero;

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign d_idx  = bus.d_pc[IDX_W+1:2];
    assign a_neg  = bus.src_a[WIDTH-1];
    assign a_zero = (bus.src_a == '0);

    always_comb begin
        cond_ok   = 1'b1;
        cond_true = 1'b0;
        case (bus.d_op)
            3'b001:  cond_true = (bus.src_a == bus.src_b);
            3'b010:  cond_true = (bus.src_a != bus.src_b);
            3'b011:  cond_true = a_neg;
            3'b100:  cond_true = ~a_neg;
            3'b101:  cond_true = a_neg | a_zero;
            3'b110:  cond_true = ~a_neg & ~a_zero;
            default: cond_ok   = 1'b0;
        endcase
        allow     = bus.d_valid & cond_ok & cond_true;
        update_en = bus.d_valid & ~bus.d_stall & cond_ok;
    end

    assign bus.allow        = allow;
    assign bus.mispredict   = ~reset & bus.d_valid & cond_ok & (allow ^ bus.d_pred_taken);
    // Reads see the registered table, so a same-cycle update is visible only next cycle.
    assign bus.f_pred_taken = pht_q[f_idx][1];

    always_comb begin
        pht_d = pht_q;
        cnt_d = pht_q[d_idx];
        if (update_en) begin
            if (allow) begin
                if (cnt_d != 2'b11) cnt_d = cnt_d + 2'b01;
            end else begin
                if (cnt_d != 2'b00) cnt_d = cnt_d - 2'b01;
            end
            pht_d[d_idx] = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CNT_INIT;
        end else begin
            pht_q <= pht_d;
        end
    end

`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_misses_q;
    logic [31:0] stat_misses_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_misses_d   = stat_misses_q;
        if (update_en && stat_branches_q != 32'hFFFF_FFFF)
            stat_branches_d = stat_branches_q + 32'd1;
        if (update_en && bus.mispredict && stat_misses_q != 32'hFFFF_FFFF)
            stat_misses_d = stat_misses_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_misses_q   <= stat_misses_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_misses   = stat_misses_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0],
                              bus.d_pc[31:IDX_W+2], bus.d_pc[1:0]};

endmodule

// File: tb/tb_branch_cmp_pht.sv
// Directed self-checking bench for branch_cmp_pht: reset, training, saturation, condition sweep, stall,
// read-before-write and aliasing. Statistics checks are included when BRANCH_CMP_STATS_EN is defined.
module tb_branch_cmp_pht;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    branch_cmp_pht_if #(.WIDTH(32)) bus ();

`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] statBranches;
    logic [31:0] statMisses;
`endif

    branch_cmp_pht dut (
        .clk           (clk),
        .reset         (reset),
`ifdef BRANCH_CMP_STATS_EN
        .stat_branches (statBranches),
        .stat_misses   (statMisses),
`endif
        .bus           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one D-stage branch and points F at the same PC, then lets the combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic stall, input logic [31:0] pc,
                                 input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic pred);
        bus.d_valid      = valid;
        bus.d_stall      = stall;
        bus.d_pc         = pc;
        bus.f_pc         = pc;
        bus.d_op         = op;
        bus.src_a        = a;
        bus.src_b        = b;
        bus.d_pred_taken = pred;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweepSrc [3];
    logic [3:0]  sweepExp [3];
    logic        ntInCycle [4];
    logic        allowExp;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        sweepSrc[0] = 32'h8000_0000; sweepExp[0] = 4'b0101;
        sweepSrc[1] = 32'h0000_0000; sweepExp[1] = 4'b0110;
        sweepSrc[2] = 32'h0000_0001; sweepExp[2] = 4'b1010;
        ntInCycle[0] = 1'b1; ntInCycle[1] = 1'b1; ntInCycle[2] = 1'b0; ntInCycle[3] = 1'b0;

        // Reset with a taken branch pending: comparator live, mispredict masked, update dropped.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rst_allow", 32'(bus.allow), 32'd1);
        checkOutput("rst_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        checkOutput("rst_pred", 32'(bus.f_pred_taken), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rst_update_dropped", 32'(bus.f_pred_taken), 32'd0);

        // First taken beq at 0x3000: 01 -> 10.
        applyStimulus(1'b1, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("t1_allow", 32'(bus.allow), 32'd1);
        checkOutput("t1_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("t1_pred_before", 32'(bus.f_pred_taken), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("t1_pred_after", 32'(bus.f_pred_taken), 32'd1);

        // Train 0x3004 up to saturation, then walk it back down.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
            checkOutput($sformatf("tk%0d_mispredict", i), 32'(bus.mispredict), 32'd0);
            tick();
            applyStimulus(1'b0, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
            checkOutput($sformatf("tk%0d_pred", i), 32'(bus.f_pred_taken), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h3004, 3'b001, 32'h1, 32'h2, 1'b0);
            checkOutput($sformatf("nt%0d_pred", i), 32'(bus.f_pred_taken), 32'(ntInCycle[i]));
            checkOutput($sformatf("nt%0d_allow", i), 32'(bus.allow), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h3004, 3'b001, 32'h1, 32'h2, 1'b0);
        checkOutput("nt_floor", 32'(bus.f_pred_taken), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
        checkOutput("floor_up1", 32'(bus.f_pred_taken), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b1);
        checkOutput("floor_up2", 32'(bus.f_pred_taken), 32'd1);

        // Signed-condition sweep, held stalled so the PHT is untouched.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                allowExp = sweepExp[s][k];
                applyStimulus(1'b1, 1'b1, 32'h3010, 3'(k + 3), sweepSrc[s], 32'hFFFF_FFFF, 1'b0);
                checkOutput($sformatf("sw_a%0d_op%0d_allow", s, k + 3), 32'(bus.allow), 32'(allowExp));
                checkOutput($sformatf("sw_a%0d_op%0d_misp", s, k + 3), 32'(bus.mispredict), 32'(allowExp));
            end
        end
        applyStimulus(1'b1, 1'b1, 32'h3010, 3'b010, 32'h1, 32'h2, 1'b0);
        checkOutput("bne_allow", 32'(bus.allow), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h3010, 3'b111, 32'h5, 32'h5, 1'b1);
        checkOutput("op7_allow", 32'(bus.allow), 32'd0);
        checkOutput("op7_mispredict", 32'(bus.mispredict), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h3010, 3'b000, 32'h5, 32'h5, 1'b1);
        checkOutput("op0_allow", 32'(bus.allow), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h3010, 3'b001, 32'h5, 32'h5, 1'b1);
        checkOutput("novalid_allow", 32'(bus.allow), 32'd0);
        checkOutput("novalid_mispredict", 32'(bus.mispredict), 32'd0);

        // Stalled taken branch at 0x3008 updates once, on release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h3008, 3'b001, 32'h5, 32'h5, 1'b0);
            tick();
            checkOutput($sformatf("stall%0d_pred", i), 32'(bus.f_pred_taken), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 32'h3008, 3'b001, 32'h5, 32'h5, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3008, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("stall_release", 32'(bus.f_pred_taken), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h3008, 3'b001, 32'h1, 32'h2, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3008, 3'b001, 32'h1, 32'h2, 1'b1);
        checkOutput("stall_single_step", 32'(bus.f_pred_taken), 32'd0);

        // Read-before-write on the same entry.
        applyStimulus(1'b1, 1'b0, 32'h300C, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rbw_same_cycle", 32'(bus.f_pred_taken), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h300C, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rbw_next_cycle", 32'(bus.f_pred_taken), 32'd1);

        // Aliasing: 0x3100 shares the entry of 0x3000 (now 10 -> 11).
        applyStimulus(1'b1, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h3100, 3'b001, 32'h5, 32'h5, 1'b1);
        checkOutput("alias_pred", 32'(bus.f_pred_taken), 32'd1);
`ifdef BRANCH_CMP_STATS_EN
        checkOutput("stat_branches", statBranches, 32'd14);
        checkOutput("stat_misses", statMisses, 32'd4);
`endif

        // Mid-run reset with a competing update at 0x3004.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h3004, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rst2_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h3000, 3'b001, 32'h5, 32'h5, 1'b0);
        checkOutput("rst2_pred_3000", 32'(bus.f_pred_taken), 32'd0);
        bus.f_pc = 32'h3100;
        #1;
        checkOutput("rst2_pred_3100", 32'(bus.f_pred_taken), 32'd0);
        bus.f_pc = 32'h3004;
        #1;
        checkOutput("rst2_pred_3004", 32'(bus.f_pred_taken), 32'd0);
`ifdef BRANCH_CMP_STATS_EN
        checkOutput("rst2_stat_branches", statBranches, 32'd0);
        checkOutput("rst2_stat_misses", statMisses, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
